fakeram_pdp_wbuf: RTL
=====================

Name: fakeram_pdp_wbuf

Overview:
- Parametrised pseudo-dual-port (1R1W) memory built from ONE single-port synchronous RAM macro.
- Successor to the fixed 32x32 two-macro dual-port emulation: generic width and depth, one macro instead of two, and coherent read-after-write.
- Reads take priority at the macro. Accepted writes are queued in a small write buffer and drained into the macro on cycles with no read.
- Sits between core-side cache/tag logic and the fakeram hard macro in NanGate45 builds.

Parameters:
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 32, number of words (power of two, >=2)
- AW, $clog2(DEPTH), address width (derived; not overridden)
- WBUF_DEPTH, 4, write-buffer entries (power of two, 2..16)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  1  write request
- w_ready  out  1  write accepted when w_valid & w_ready
- w_addr  in  AW  write address
- w_data  in  WIDTH  write data
- r_valid  in  1  read request
- r_ready  out  1  read accepted when r_valid & r_ready
- r_addr  in  AW  read address
- r_data  out  WIDTH  read data
- r_data_valid  out  1  one-cycle pulse, r_data valid
- wbuf_empty  out  1  write buffer empty (all writes committed)

Behaviour:
- Reset (async assert, sync deassert handled upstream): buffer empty, count 0, r_data=0, r_data_valid=0, wbuf_empty=1, w_ready=1. Contents of the macro are undefined after reset.
- Handshakes:
  - w_ready = !full.
  - r_ready = !full, so a full buffer forces a drain cycle and reads cannot starve writes.
- Macro port arbitration, per cycle:
  - Read handshake → macro read at r_addr.
  - Else if buffer non-empty → macro write of the head entry, then pop.
  - Else idle (ce inactive).
- Read latency: r_data and r_data_valid appear exactly 1 cycle after the accepting edge. r_data holds its value until the next read; r_data_valid is a pulse.
- Ordering: a read sees every write accepted in earlier cycles. A write accepted in the same cycle as a read is NOT visible to that read.
- Simultaneous push and pop: count is unchanged, and the pointers wrap modulo WBUF_DEPTH.
- Several buffered writes to the same address are committed in order, so the last write wins.
- Reset mid-operation discards buffered writes (they are not committed) and kills any in-flight r_data_valid.
- Width rules: the address is compared over the full AW bits. The macro write mask is tied all-ones.

Optional Feature:
- Macro: FAKERAM_PDP_BYPASS_EN
- Defined:
  - Each accepted read compares r_addr against all valid buffer entries.
  - On a match, the youngest matching entry's data is registered and returned with the same 1-cycle latency, overriding the macro output.
  - r_ready is unaffected.
- Undefined:
  - No forwarding datapath.
  - r_ready is additionally deasserted while any valid buffer entry matches r_addr. The drain proceeds, so coherence is kept at the cost of stall cycles.

Decomposition:
- Package fakeram_pdp_pkg:
  - wbuf_entry_t struct {addr, data}, parameterised via localparam widths.
  - Macro-port op enum {OP_IDLE, OP_RD, OP_WR}.
  - Default constants.
- One sub-module, fakeram_pdp_wbuf_fifo:
  - Circular write buffer with head/tail/count and full/empty.
  - Exposes all entries plus per-entry valid bits for the match logic.
- The top level holds the arbitration, the match/forward logic and the macro instance (behavioural array model under simulation).

Test Plan:
- Write 0x0000_00A5 @3; idle 1 cycle; read @3 → r_data_valid at +1 cycle, r_data=0x0000_00A5, wbuf_empty=1 before the read.
- Continuous reads (r_valid=1) with 4 writes accepted (WBUF_DEPTH=4) → w_ready=0 and r_ready=0 while full. Next cycle one drain occurs, count=3, w_ready=1 and r_ready=1.
- Writes 0x11, 0x22 @5 back-to-back, then read @5 while both are still buffered:
  - With BYPASS → 0x22 at +1 cycle.
  - Without BYPASS → r_ready=0 until the buffer has no @5 entry, then 0x22.
- Read @7 and write 0xFF @7 accepted in the same cycle, with old value 0x33 → r_data=0x33. A later read @7 → 0xFF.
- Fill the buffer with 3 writes, assert rst_n=0 mid-drain → immediately wbuf_empty=1, r_data_valid=0, r_data=0. Only writes already drained persist.
- 1000 random R/W cycles (DEPTH=32, WIDTH=32) against a reference model → every r_data matches and the pointers wrap cleanly.

Source files
------------

// File: rtl/fakeram_pdp_pkg.sv
// Shared types and default sizing for the single-macro pseudo-dual-port RAM.
package fakeram_pdp_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_WBUF_DEPTH = 4;
  localparam int DEF_AW         = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_AW-1:0]    addr;
    logic [DEF_WIDTH-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;

endpackage

// File: rtl/fakeram_pdp_wbuf_fifo.sv
// Circular write buffer; entries are presented oldest-first (index 0 = head)
// together with a valid bit each, so the top can match and forward by age.
module fakeram_pdp_wbuf_fifo
  import fakeram_pdp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int AW         = DEF_AW,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW-1:0]    ent_addr [WBUF_DEPTH],
  output logic [WIDTH-1:0] ent_data [WBUF_DEPTH],
  output logic [WBUF_DEPTH-1:0] ent_valid
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [WBUF_DEPTH];
  logic [WIDTH-1:0] data_q [WBUF_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  // Pointers are PW bits wide, so wrap modulo WBUF_DEPTH comes for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  for (genvar k = 0; k < WBUF_DEPTH; k++) begin : g_ent
    assign ent_addr[k]  = addr_q[head + PW'(k)];
    assign ent_data[k]  = data_q[head + PW'(k)];
    assign ent_valid[k] = CW'(k) < count;
  end

  assign full  = (count == CW'(WBUF_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fakeram_pdp_wbuf.sv
// 1R1W memory on one single-port macro with a drain-on-idle write buffer.
// FAKERAM_PDP_BYPASS_EN: forward buffered data to reads instead of stalling them.
module fakeram_pdp_wbuf
  import fakeram_pdp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [AW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data,
  output logic             r_data_valid,
  output logic             wbuf_empty
);

  localparam logic [WIDTH-1:0] WMASK = '1;

  logic                  full;
  logic                  empty;
  logic [AW-1:0]         ent_addr [WBUF_DEPTH];
  logic [WIDTH-1:0]      ent_data [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] ent_valid;
  logic [WBUF_DEPTH-1:0] ent_hit;
  logic                  w_fire;
  logic                  rd_fire;
  op_e                   op;

  fakeram_pdp_wbuf_fifo #(
    .WIDTH(WIDTH), .AW(AW), .WBUF_DEPTH(WBUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_fire),
    .push_addr (w_addr),
    .push_data (w_data),
    .pop       (op == OP_WR),
    .full      (full),
    .empty     (empty),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .ent_valid (ent_valid)
  );

  always_comb begin
    ent_hit = '0;
    for (int k = 0; k < WBUF_DEPTH; k++)
      ent_hit[k] = ent_valid[k] && (ent_addr[k] == r_addr);
  end

  assign w_ready = !full;
`ifdef FAKERAM_PDP_BYPASS_EN
  assign r_ready = !full;
`else
  // Without forwarding, hold the read off until the drain retires every hit.
  assign r_ready = !full && !(|ent_hit);
`endif
  assign w_fire  = w_valid && w_ready;
  assign rd_fire = r_valid && r_ready;

  always_comb begin
    op = OP_IDLE;
    if (rd_fire)     op = OP_RD;
    else if (!empty) op = OP_WR;
  end

  // ---- p0 -> p1: macro access (behavioural single-port array) ----
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_q_p1;
  logic [WIDTH-1:0] rd_word_p1;
  logic [WIDTH-1:0] rd_hold_p2;
  logic             vld_p1;

  always_ff @(posedge clk) begin
    if (op == OP_WR)
      mem[ent_addr[0]] <= (ent_data[0] & WMASK) | (mem[ent_addr[0]] & ~WMASK);
    if (op == OP_RD)
      mem_q_p1 <= mem[r_addr];
  end

`ifdef FAKERAM_PDP_BYPASS_EN
  logic             byp_hit_p1;
  logic [WIDTH-1:0] byp_data;
  logic [WIDTH-1:0] byp_data_p1;

  // Entries are oldest-first, so the last hit in the scan is the youngest.
  always_comb begin
    byp_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++)
      if (ent_hit[k]) byp_data = ent_data[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       byp_hit_p1 <= 1'b0;
    else if (rd_fire) byp_hit_p1 <= |ent_hit;
  end

  always_ff @(posedge clk) begin
    if (rd_fire) byp_data_p1 <= byp_data;
  end

  assign rd_word_p1 = byp_hit_p1 ? byp_data_p1 : mem_q_p1;
`else
  assign rd_word_p1 = mem_q_p1;
`endif

  // ---- p1 -> p2: valid pulse and held read data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      rd_hold_p2 <= '0;
    end else begin
      vld_p1 <= rd_fire;
      if (vld_p1) rd_hold_p2 <= rd_word_p1;
    end
  end

  assign r_data       = vld_p1 ? rd_word_p1 : rd_hold_p2;
  assign r_data_valid = vld_p1;
  assign wbuf_empty   = empty;

endmodule
